clic_irq_tx: RTL and testbench
==============================

Name: clic_irq_tx

Overview:
- CLIC-side interrupt transmitter feeding the core's interrupt interface.
- Arbitrates pending, enabled sources by level, with ties going to the lowest index.
- Drives a one-hot irq_o plus irq_level_o and holds them stable until the core acknowledges.
- Clears edge-triggered pending state on acknowledge, then re-arbitrates. This is the source end of the core's irq_i / irq_level_i / irq_ack_o handshake.

Parameters:
- NumSrc, 64, number of interrupt sources (matches ArianeCfg.CLICNumInterruptSrc); power of two, >= 2.
- IdWidth, $clog2(NumSrc), width of source id (derived, do not override).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous reset, active-high
- src_pending_i  in  NumSrc  raw pending per source (level-sensitive sources hold it high)
- src_enable_i  in  NumSrc  per-source enable (clicintie)
- src_edge_i  in  NumSrc  1 = source is edge-triggered; its pending is cleared by edge_clear_o
- src_level_i  in  NumSrc*8  per-source 8-bit level; source k at [8k+7:8k]
- irq_o  out  NumSrc  one-hot interrupt request to core (all-zero = none)
- irq_level_o  out  8  level of the source driven on irq_o
- irq_ack_i  in  1  core handshake; single-cycle pulse when the core takes the interrupt
- irq_ack_id_i  in  IdWidth  id the core reports taking
- edge_clear_o  out  NumSrc  one-hot, one-cycle pulse clearing pending of the acked edge source
- ack_err_o  out  1  one-cycle pulse on a protocol violation

Behaviour:
- Clock and reset: one clock (clk_i). Reset rst_i is synchronous and active-high.
- Reset values: irq_o=0, irq_level_o=0, edge_clear_o=0, ack_err_o=0, state=IDLE, win_id=0, win_lvl=0.
- Candidate definition: cand[k] = src_pending_i[k] & src_enable_i[k].
- Arbitration (combinational over cand):
  - Winner is the max src_level_i, ties resolved to the lowest k.
  - Compares are unsigned 8-bit.
  - any_cand = |cand.
- FSM states: IDLE, REQ, ACKED.
- IDLE:
  - irq_o=0.
  - If any_cand: register win_id/win_lvl and go to REQ. irq_o becomes onehot(win_id) the next cycle, so pending at edge N gives irq_o at N+1.
- REQ:
  - irq_o=onehot(win_id), irq_level_o=win_lvl.
  - irq_ack_i has priority over the two cases below:
    - go to ACKED;
    - if irq_ack_id_i != win_id, pulse ack_err_o; the acked id is still taken as win_id;
    - if src_edge_i[win_id], pulse edge_clear_o[win_id] in the cycle after the ack.
  - Else if cand[win_id]=0 (withdrawn/disabled): go to IDLE, irq_o=0 next cycle.
  - Else if the arbitration winner has level > win_lvl: replace win_id/win_lvl (preemption before ack). An equal level never switches.
  - Else: hold. irq_o and irq_level_o are bit-stable while in REQ without preemption.
- ACKED:
  - Lasts exactly one cycle. irq_o=0, edge_clear_o pulse driven here.
  - Then go to IDLE, unconditionally.
  - Earliest next irq_o is ack edge + 3 cycles. This gives the pending register time to drop.
- irq_ack_i in IDLE or ACKED: ignored for state; pulse ack_err_o next cycle.
- irq_level_o in IDLE and ACKED: holds the last win_lvl. The core qualifies on |irq_o.
- Invariants:
  - irq_o is one-hot or zero in every cycle ($onehot0 assertion).
  - edge_clear_o is never asserted outside the cycle following a REQ-state ack.
- Reset mid-operation: rst_i in any state gives all outputs their reset values next cycle. Any pending edge_clear_o pulse is dropped.
- All outputs are registered. There is no combinational path from any input to any output.

Test Plan:
- Reset, then cand[5]=1 with level 0x40 at edge N -> irq_o=1<<5, irq_level_o=0x40 at N+1, held until ack.
- cand[3] level 0x20 and cand[9] level 0x20 together -> irq_o=1<<3. Add cand[12] level 0x21 while in REQ -> irq_o=1<<12 next cycle, irq_level_o=0x21.
- Edge source 7 in REQ, irq_ack_i with id 7 at edge N -> irq_o=0 and edge_clear_o=1<<7 at N+1 only. Pending dropped -> IDLE, no re-request. Level source 7 still pending -> irq_o=1<<7 again at N+3.
- In REQ on source 4, deassert src_enable_i[4] -> irq_o=0 next cycle, no edge_clear_o, no ack_err_o.
- Ack with id 2 while win_id=6 -> ack_err_o pulse, edge_clear_o=1<<6 (edge source), FSM ACKED. Ack in IDLE -> ack_err_o pulse only.
- rst_i asserted in ACKED -> edge_clear_o=0, irq_o=0, irq_level_o=0 next cycle. Random stimulus for 10k cycles -> $onehot0(irq_o) always holds.

Source files
------------

// File: rtl/clic_irq_tx.sv
// CLIC-side interrupt transmitter: picks the highest-level pending, enabled source
// (lowest index on ties) and presents it on a one-hot irq/level/ack handshake.
module clic_irq_tx #(
  parameter  int NumSrc  = 64,
  localparam int IdWidth = $clog2(NumSrc)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [NumSrc-1:0]     src_pending_i,
  input  logic [NumSrc-1:0]     src_enable_i,
  input  logic [NumSrc-1:0]     src_edge_i,
  input  logic [NumSrc*8-1:0]   src_level_i,
  output logic [NumSrc-1:0]     irq_o,
  output logic [7:0]            irq_level_o,
  input  logic                  irq_ack_i,
  input  logic [IdWidth-1:0]    irq_ack_id_i,
  output logic [NumSrc-1:0]     edge_clear_o,
  output logic                  ack_err_o
);

  typedef enum logic [1:0] {IDLE, REQ, ACKED} state_t;

  state_t              r_state;
  logic [IdWidth-1:0]  r_win_id;
  logic [7:0]          r_win_lvl;
  logic [NumSrc-1:0]   r_irq;
  logic [NumSrc-1:0]   r_edge_clear;
  logic                r_ack_err;

  logic [NumSrc-1:0]   w_cand;
  logic [7:0]          w_lvl [NumSrc];
  logic                w_any_cand;
  logic [IdWidth-1:0]  w_arb_id;
  logic [7:0]          w_arb_lvl;

  function automatic logic [NumSrc-1:0] onehot(input logic [IdWidth-1:0] id);
    logic [NumSrc-1:0] v;
    v = '0;
    v[id] = 1'b1;
    return v;
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < NumSrc; gi++) begin : g_src
      assign w_cand[gi] = src_pending_i[gi] & src_enable_i[gi];
      assign w_lvl[gi]  = src_level_i[8*gi +: 8];
    end
  endgenerate

  // Ascending scan with a strict compare keeps the lowest index on equal levels.
  always_comb begin
    w_any_cand = 1'b0;
    w_arb_id   = '0;
    w_arb_lvl  = '0;
    for (int k = 0; k < NumSrc; k++) begin
      if (w_cand[k] && (!w_any_cand || (w_lvl[k] > w_arb_lvl))) begin
        w_any_cand = 1'b1;
        w_arb_id   = IdWidth'(k);
        w_arb_lvl  = w_lvl[k];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state      <= IDLE;
      r_win_id     <= '0;
      r_win_lvl    <= '0;
      r_irq        <= '0;
      r_edge_clear <= '0;
      r_ack_err    <= 1'b0;
    end else begin
      r_edge_clear <= '0;
      r_ack_err    <= 1'b0;
      case (r_state)
        IDLE: begin
          r_ack_err <= irq_ack_i;
          if (w_any_cand) begin
            r_state   <= REQ;
            r_win_id  <= w_arb_id;
            r_win_lvl <= w_arb_lvl;
            r_irq     <= onehot(w_arb_id);
          end
        end
        REQ: begin
          if (irq_ack_i) begin
            // A mismatched id is flagged, but the presented source is still retired.
            r_state   <= ACKED;
            r_irq     <= '0;
            r_ack_err <= (irq_ack_id_i != r_win_id);
            if (src_edge_i[r_win_id]) begin
              r_edge_clear <= onehot(r_win_id);
            end
          end else if (!w_cand[r_win_id]) begin
            r_state <= IDLE;
            r_irq   <= '0;
          end else if (w_arb_lvl > r_win_lvl) begin
            r_win_id  <= w_arb_id;
            r_win_lvl <= w_arb_lvl;
            r_irq     <= onehot(w_arb_id);
          end
        end
        ACKED: begin
          r_state   <= IDLE;
          r_irq     <= '0;
          r_ack_err <= irq_ack_i;
        end
        default: begin
          r_state <= IDLE;
          r_irq   <= '0;
        end
      endcase
    end
  end

  assign irq_o        = r_irq;
  assign irq_level_o  = r_win_lvl;
  assign edge_clear_o = r_edge_clear;
  assign ack_err_o    = r_ack_err;

endmodule

// File: tb/tb_clic_irq_tx.sv
// Directed and random checks of clic_irq_tx against a cycle-level behavioural model.
module tb_clic_irq_tx;
  localparam int N  = 64;
  localparam int IW = $clog2(N);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst;
  logic [N-1:0]    pend, en, edg;
  logic [N*8-1:0]  lvls;
  logic            ack;
  logic [IW-1:0]   ack_id;
  logic [N-1:0]    irq;
  logic [7:0]      irq_lvl;
  logic [N-1:0]    clr;
  logic            err;

  int errors = 0;
  int checks = 0;

  // Model view: who is being presented, and whether we are in the post-ack bubble.
  logic [N-1:0] m_irq, m_clr;
  logic [7:0]   m_lvl;
  logic         m_err;
  bit           m_serving, m_retire;
  int           m_id;

  clic_irq_tx #(.NumSrc(N)) dut (
    .clk_i(clk), .rst_i(rst),
    .src_pending_i(pend), .src_enable_i(en), .src_edge_i(edg), .src_level_i(lvls),
    .irq_o(irq), .irq_level_o(irq_lvl),
    .irq_ack_i(ack), .irq_ack_id_i(ack_id),
    .edge_clear_o(clr), .ack_err_o(err)
  );

  task automatic chk(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] lvl_of(input int k);
    return lvls[8*k +: 8];
  endfunction

  // Next-cycle outputs from the rules: highest level wins, first index among equals.
  task automatic model_step();
    logic [N-1:0] cand;
    int top, pick;
    cand = pend & en;
    top = -1;
    pick = -1;
    for (int k = 0; k < N; k++)
      if (cand[k] && int'(lvl_of(k)) > top) top = int'(lvl_of(k));
    for (int k = 0; k < N; k++)
      if (pick < 0 && cand[k] && int'(lvl_of(k)) == top) pick = k;
    m_clr = '0;
    m_err = 1'b0;
    if (rst) begin
      m_irq = '0; m_lvl = 8'h00; m_id = 0; m_serving = 0; m_retire = 0;
    end else if (m_retire) begin
      m_retire = 0; m_irq = '0; m_err = ack;
    end else if (m_serving) begin
      if (ack) begin
        m_serving = 0; m_retire = 1; m_irq = '0;
        m_err = (int'(ack_id) != m_id);
        if (edg[m_id]) m_clr[m_id] = 1'b1;
      end else if (!cand[m_id]) begin
        m_serving = 0; m_irq = '0;
      end else if (top > int'(m_lvl)) begin
        m_id = pick; m_lvl = 8'(top); m_irq = '0; m_irq[pick] = 1'b1;
      end
    end else begin
      m_err = ack;
      if (pick >= 0) begin
        m_serving = 1; m_id = pick; m_lvl = 8'(top); m_irq = '0; m_irq[pick] = 1'b1;
      end
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    chk("m_irq", irq, m_irq);
    chk("m_lvl", N'(irq_lvl), N'(m_lvl));
    chk("m_clr", clr, m_clr);
    chk("m_err", N'(err), N'(m_err));
    checks++;
    assert ($onehot0(irq)) else begin
      errors++;
      $error("FAIL onehot0 got=%h exp=onehot0", irq);
    end
  endtask

  task automatic expect_out(input string tag, input logic [N-1:0] e_irq, input logic [7:0] e_lvl,
                            input logic [N-1:0] e_clr, input logic e_err);
    chk({tag, "_irq"}, irq, e_irq);
    chk({tag, "_lvl"}, N'(irq_lvl), N'(e_lvl));
    chk({tag, "_clr"}, clr, e_clr);
    chk({tag, "_err"}, N'(err), N'(e_err));
  endtask

  function automatic logic [N-1:0] bit_of(input int k);
    logic [N-1:0] v;
    v = '0;
    v[k] = 1'b1;
    return v;
  endfunction

  initial begin
    m_irq = '0; m_clr = '0; m_lvl = 8'h00; m_err = 1'b0; m_id = 0; m_serving = 0; m_retire = 0;
    rst = 1'b1; pend = '0; en = '1; edg = '0; lvls = '0; ack = 1'b0; ack_id = '0;
    cycle(); cycle();
    expect_out("reset", '0, 8'h00, '0, 1'b0);
    rst = 1'b0;
    cycle();

    // Single level source, held until acked.
    pend[5] = 1'b1; lvls[8*5 +: 8] = 8'h40;
    cycle(); expect_out("first_req", bit_of(5), 8'h40, '0, 1'b0);
    cycle(); cycle(); expect_out("hold", bit_of(5), 8'h40, '0, 1'b0);
    ack = 1'b1; ack_id = IW'(5);
    cycle(); expect_out("ack_lvl", '0, 8'h40, '0, 1'b0);
    ack = 1'b0; pend = '0;
    cycle();

    // Tie goes to lowest index; a strictly higher level preempts.
    pend[3] = 1'b1; pend[9] = 1'b1; lvls[8*3 +: 8] = 8'h20; lvls[8*9 +: 8] = 8'h20;
    cycle(); expect_out("tie", bit_of(3), 8'h20, '0, 1'b0);
    pend[12] = 1'b1; lvls[8*12 +: 8] = 8'h21;
    cycle(); expect_out("preempt", bit_of(12), 8'h21, '0, 1'b0);
    pend = '0;
    cycle(); expect_out("withdraw", '0, 8'h21, '0, 1'b0);

    // Edge source acked: clear pulse, no re-request once pending drops.
    edg[7] = 1'b1; pend[7] = 1'b1; lvls[8*7 +: 8] = 8'h10;
    cycle(); expect_out("edge_req", bit_of(7), 8'h10, '0, 1'b0);
    ack = 1'b1; ack_id = IW'(7);
    cycle(); expect_out("edge_ack", '0, 8'h10, bit_of(7), 1'b0);
    ack = 1'b0; pend[7] = 1'b0;
    cycle(); expect_out("edge_after", '0, 8'h10, '0, 1'b0);
    cycle(); expect_out("edge_idle", '0, 8'h10, '0, 1'b0);

    // Level source still pending: re-requested three edges after the ack.
    edg[7] = 1'b0; pend[7] = 1'b1;
    cycle();
    ack = 1'b1; ack_id = IW'(7);
    cycle(); expect_out("lvl_n1", '0, 8'h10, '0, 1'b0);
    ack = 1'b0;
    cycle(); expect_out("lvl_n2", '0, 8'h10, '0, 1'b0);
    cycle(); expect_out("lvl_n3", bit_of(7), 8'h10, '0, 1'b0);
    pend = '0;
    cycle();

    // Disable withdraws the request silently.
    pend[4] = 1'b1; lvls[8*4 +: 8] = 8'h30;
    cycle(); expect_out("dis_req", bit_of(4), 8'h30, '0, 1'b0);
    en[4] = 1'b0;
    cycle(); expect_out("dis", '0, 8'h30, '0, 1'b0);
    en = '1; pend = '0;
    cycle();

    // Wrong-id ack still retires the presented edge source; ack in IDLE only errors.
    edg[6] = 1'b1; pend[6] = 1'b1; lvls[8*6 +: 8] = 8'h50;
    cycle(); expect_out("bad_req", bit_of(6), 8'h50, '0, 1'b0);
    ack = 1'b1; ack_id = IW'(2);
    cycle(); expect_out("bad_ack", '0, 8'h50, bit_of(6), 1'b1);
    ack = 1'b0; pend = '0;
    cycle(); expect_out("bad_after", '0, 8'h50, '0, 1'b0);
    ack = 1'b1;
    cycle(); expect_out("idle_ack", '0, 8'h50, '0, 1'b1);
    ack = 1'b0;
    cycle(); expect_out("idle_after", '0, 8'h50, '0, 1'b0);

    // Reset in the post-ack cycle, then reset coinciding with an ack.
    pend[6] = 1'b1;
    cycle();
    ack = 1'b1; ack_id = IW'(6);
    cycle(); expect_out("rst_acked", '0, 8'h50, bit_of(6), 1'b0);
    ack = 1'b0; rst = 1'b1;
    cycle(); expect_out("rst_in_acked", '0, 8'h00, '0, 1'b0);
    rst = 1'b0;
    cycle(); expect_out("rst_rereq", bit_of(6), 8'h50, '0, 1'b0);
    ack = 1'b1; rst = 1'b1;
    cycle(); expect_out("rst_with_ack", '0, 8'h00, '0, 1'b0);
    ack = 1'b0; rst = 1'b0; pend = '0; edg = '0;
    cycle();

    // Random traffic against the model.
    for (int k = 0; k < N; k++) begin
      edg[k] = ($urandom_range(0, 2) == 0);
      lvls[8*k +: 8] = 8'($urandom_range(0, 3) * 64);
    end
    for (int c = 0; c < 10000; c++) begin
      int s;
      rst = ($urandom_range(0, 999) == 0);
      for (int k = 0; k < N; k++) if (m_clr[k]) pend[k] = 1'b0;
      if ($urandom_range(0, 3) == 0) begin s = $urandom_range(0, N-1); pend[s] = ~pend[s]; end
      if ($urandom_range(0, 15) == 0) begin s = $urandom_range(0, N-1); en[s] = ~en[s]; end
      if ($urandom_range(0, 15) == 0) begin
        s = $urandom_range(0, N-1);
        lvls[8*s +: 8] = 8'($urandom_range(0, 3) * 64 + $urandom_range(0, 1));
      end
      ack = m_serving ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 39) == 0);
      ack_id = ($urandom_range(0, 4) == 0) ? IW'($urandom_range(0, N-1)) : IW'(m_id);
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
